avalon_aon_timer: RTL and testbench
===================================

AVALON_AON_TIMER -- requirements
Module: avalon_aon_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50, meaning clk cycles per mtime tick (1 MHz at 50 MHz clk); legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port avn_read  input  1  Avalon read request.
REQ-005 SHALL have port avn_write  input  1  Avalon write request.
REQ-006 SHALL have port avn_address  input  5  byte address; bits [1:0] ignored.
REQ-007 SHALL have port avn_byte_enable  input  4  write byte lanes.
REQ-008 SHALL have port avn_writedata  input  32  write data.
REQ-009 SHALL have port avn_readdata  output  32  read data, valid when avn_read=1 and avn_waitrequest=0.
REQ-010 SHALL have port avn_waitrequest  output  1  stall to master.
REQ-011 SHALL have port software_interrupt  output  1  to core.
REQ-012 SHALL have port timer_interrupt  output  1  to core.

Function
REQ-013 Register map SHALL be: 0x00 MSIP (bit0 only), 0x04 CTRL (bit0 enable), 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 MTIME_LO, 0x14 MTIME_HI.
REQ-014 Reads of unmapped offsets (0x18-0x1C) SHALL return 0; writes there SHALL be ignored; unused register bits SHALL read 0.
REQ-015 Writes SHALL complete in the request cycle with avn_waitrequest=0; each byte lane updates only if its avn_byte_enable bit is 1.
REQ-016 Reads SHALL take two cycles: first cycle of avn_read, avn_waitrequest=1 and data registered; next cycle avn_waitrequest=0 and avn_readdata valid; master holds avn_read until then.
REQ-017 avn_read and avn_write both asserted SHALL be treated as a write; the read is not serviced.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 while CTRL.enable=1, wrapping to 0 and emitting a one-cycle tick at PRESCALE-1; PRESCALE=1 ticks every cycle.
REQ-019 CTRL.enable=0 SHALL freeze the prescaler and mtime at their current values.
REQ-020 mtime (64-bit) SHALL increment by 1 per tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-021 A write to MTIME_LO/HI in a tick cycle SHALL take priority; the written half takes the write data, the other half is unchanged (no increment or carry that cycle); prescaler is unaffected.
REQ-022 Reading MTIME_LO SHALL capture mtime[63:32] into a shadow register in the same cycle; reading MTIME_HI SHALL return the shadow, giving a coherent 64-bit read for the LO-then-HI sequence.
REQ-023 timer_interrupt SHALL be a register loaded each cycle with (mtime >= mtimecmp), unsigned 64-bit, one cycle after any change of mtime or mtimecmp.
REQ-024 software_interrupt SHALL equal MSIP bit0 directly from its register.

Reset
REQ-025 On rst_n=0, asynchronously: mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, MSIP=0, CTRL.enable=1, shadow=0, avn_readdata=0, avn_waitrequest=0, timer_interrupt=0, software_interrupt=0.
REQ-026 Reset asserted mid-read SHALL abort the read; after rst_n deasserts the master must reissue it.
REQ-027 First tick after reset release SHALL occur PRESCALE cycles after the first rising edge with rst_n=1.

Verification
REQ-028 PRESCALE=4, no bus traffic, 40 cycles after reset -> mtime reads 10, timer_interrupt=0.
REQ-029 Write MTIMECMP_HI=0, MTIMECMP_LO=5 -> timer_interrupt rises exactly one cycle after mtime reaches 5; write MTIMECMP_LO=0xFFFF_FFFF -> falls one cycle later.
REQ-030 Write MTIME_HI=0, MTIME_LO=0xFFFF_FFFF, read LO then HI across the next tick -> LO=0xFFFF_FFFF, HI=0 (shadow); fresh LO/HI pair afterwards reads 0x0000_0001_0000_0000.
REQ-031 Write MSIP=0xFFFF_FFFF with byte_enable=4'b0001 -> software_interrupt=1, MSIP reads 1; byte_enable=4'b1110 with data 0 -> no change.
REQ-032 CTRL=0 for 100 cycles -> mtime unchanged; MTIME_LO write coinciding with a tick -> written value held, no increment that cycle.
REQ-033 Assert rst_n=0 during read wait cycle -> all outputs at reset values immediately, avn_waitrequest=0, mtimecmp reads 0xFFFF_FFFF both halves.

Source files
------------

// File: rtl/avalon_aon_timer.sv
// Always-on machine timer with an Avalon-MM slave: MSIP, CTRL, 64-bit mtime/mtimecmp.
// Writes complete in one cycle; reads take two (capture, then present).
module avalon_aon_timer #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        avn_read,
    input  logic        avn_write,
    input  logic [4:0]  avn_address,
    input  logic [3:0]  avn_byte_enable,
    input  logic [31:0] avn_writedata,
    output logic [31:0] avn_readdata,
    output logic        avn_waitrequest,
    output logic        software_interrupt,
    output logic        timer_interrupt
);
    localparam int unsigned PS_W = 16;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    localparam logic [2:0] A_MSIP     = 3'd0;
    localparam logic [2:0] A_CTRL     = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_MTIME_LO = 3'd4;
    localparam logic [2:0] A_MTIME_HI = 3'd5;

    typedef enum logic {RD_IDLE, RD_DONE} rd_state_e;

    rd_state_e        rd_state_q, rd_state_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q, msip_d;
    logic             enable_q, enable_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             tirq_q;
    logic             wait_c, capture_c, tick_c;
    logic [31:0]      rdata_c;
    logic [2:0]       idx;
    logic             addr_unused;

    assign idx         = avn_address[4:2];
    assign addr_unused = ^avn_address[1:0];

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        lane_merge = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) lane_merge[8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    // Read handshake: stall the first read cycle while data is captured.
    always_comb begin
        rd_state_d = rd_state_q;
        wait_c     = 1'b0;
        capture_c  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (avn_read && !avn_write) begin
                    wait_c     = 1'b1;
                    capture_c  = 1'b1;
                    rd_state_d = RD_DONE;
                end
            end
            RD_DONE: rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rdata_c = 32'd0;
        case (idx)
            A_MSIP:     rdata_c = {31'd0, msip_q};
            A_CTRL:     rdata_c = {31'd0, enable_q};
            A_CMP_LO:   rdata_c = mtimecmp_q[31:0];
            A_CMP_HI:   rdata_c = mtimecmp_q[63:32];
            A_MTIME_LO: rdata_c = mtime_q[31:0];
            A_MTIME_HI: rdata_c = shadow_q;
            default:    rdata_c = 32'd0;
        endcase
    end

    assign tick_c = enable_q && (ps_q == PS_MAX);

    // Register updates; a bus write to mtime overrides that cycle's tick.
    always_comb begin
        ps_d       = ps_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        enable_d   = enable_q;
        shadow_d   = shadow_q;
        readdata_d = readdata_q;

        if (enable_q) ps_d = tick_c ? '0 : ps_q + PS_W'(1);

        if (avn_write && idx == A_MTIME_LO) begin
            mtime_d[31:0] = lane_merge(mtime_q[31:0], avn_writedata, avn_byte_enable);
        end else if (avn_write && idx == A_MTIME_HI) begin
            mtime_d[63:32] = lane_merge(mtime_q[63:32], avn_writedata, avn_byte_enable);
        end else if (tick_c) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (avn_write) begin
            case (idx)
                A_MSIP:   if (avn_byte_enable[0]) msip_d = avn_writedata[0];
                A_CTRL:   if (avn_byte_enable[0]) enable_d = avn_writedata[0];
                A_CMP_LO: mtimecmp_d[31:0] = lane_merge(mtimecmp_q[31:0], avn_writedata, avn_byte_enable);
                A_CMP_HI: mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], avn_writedata, avn_byte_enable);
                default:  ;
            endcase
        end

        if (capture_c) begin
            readdata_d = rdata_c;
            if (idx == A_MTIME_LO) shadow_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            ps_q       <= '0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            enable_q   <= 1'b1;
            shadow_q   <= 32'd0;
            readdata_q <= 32'd0;
            tirq_q     <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            ps_q       <= ps_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            enable_q   <= enable_d;
            shadow_q   <= shadow_d;
            readdata_q <= readdata_d;
            tirq_q     <= (mtime_q >= mtimecmp_q);
        end
    end

    // Stall is forced low while reset is held so an aborted read releases the master.
    assign avn_waitrequest    = rst_n & wait_c;
    assign avn_readdata       = readdata_q;
    assign timer_interrupt    = tirq_q;
    assign software_interrupt = msip_q;

endmodule

// File: tb/tb_avalon_aon_timer.sv
// Bench for avalon_aon_timer: register table, directed timer corner cases and
// random bus traffic checked against a cycle-count reference model.
module tb_avalon_aon_timer;
    localparam int unsigned PRE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        avn_read = 1'b0;
    logic        avn_write = 1'b0;
    logic [4:0]  avn_address = 5'd0;
    logic [3:0]  avn_byte_enable = 4'd0;
    logic [31:0] avn_writedata = 32'd0;
    logic [31:0] avn_readdata;
    logic        avn_waitrequest;
    logic        software_interrupt;
    logic        timer_interrupt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    avalon_aon_timer #(.PRESCALE(PRE)) dut (
        .clk(clk), .rst_n(rst_n),
        .avn_read(avn_read), .avn_write(avn_write),
        .avn_address(avn_address), .avn_byte_enable(avn_byte_enable),
        .avn_writedata(avn_writedata), .avn_readdata(avn_readdata),
        .avn_waitrequest(avn_waitrequest),
        .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: mtime advances once per PRE enabled cycles since reset.
    logic [63:0] m_mtime, m_cmp;
    logic        m_msip, m_en, m_tirq, m_tick;
    int unsigned m_encnt;
    logic [31:0] tb_shadow;

    assign m_tick = m_en && ((m_encnt % PRE) == PRE - 1);

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime <= 64'd0; m_cmp <= '1; m_msip <= 1'b0; m_en <= 1'b1;
            m_encnt <= 0; m_tirq <= 1'b0;
        end else begin
            if (m_en) m_encnt <= m_encnt + 1;
            m_tirq <= (m_mtime >= m_cmp);
            if (avn_write) begin
                case (avn_address[4:2])
                    3'd0: if (avn_byte_enable[0]) m_msip <= avn_writedata[0];
                    3'd1: if (avn_byte_enable[0]) m_en <= avn_writedata[0];
                    3'd2: m_cmp[31:0]    <= merge(m_cmp[31:0], avn_writedata, avn_byte_enable);
                    3'd3: m_cmp[63:32]   <= merge(m_cmp[63:32], avn_writedata, avn_byte_enable);
                    3'd4: m_mtime[31:0]  <= merge(m_mtime[31:0], avn_writedata, avn_byte_enable);
                    3'd5: m_mtime[63:32] <= merge(m_mtime[63:32], avn_writedata, avn_byte_enable);
                    default: ;
                endcase
            end
            if (m_tick && !(avn_write && (avn_address[4:2] == 3'd4 || avn_address[4:2] == 3'd5)))
                m_mtime <= m_mtime + 64'd1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a[4:2])
            3'd0: return {31'd0, m_msip};
            3'd1: return {31'd0, m_en};
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return m_mtime[31:0];
            3'd5: return tb_shadow;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("timer_interrupt", 64'(timer_interrupt), 64'(m_tirq));
        chk("software_interrupt", 64'(software_interrupt), 64'(m_msip));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be, input logic also_rd);
        avn_write = 1'b1; avn_read = also_rd;
        avn_address = a; avn_writedata = d; avn_byte_enable = be;
        #1;
        chk("wr_waitrequest", 64'(avn_waitrequest), 64'd0);
        step();
        avn_write = 1'b0; avn_read = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [4:0] a, output logic [31:0] d);
        logic [31:0] e;
        int n;
        e = exp_rd(a);
        if (a[4:2] == 3'd4) tb_shadow = m_mtime[63:32];
        avn_read = 1'b1; avn_address = a;
        #1;
        chk({nm, "_wait1"}, 64'(avn_waitrequest), 64'd1);
        @(posedge clk); #1;
        n = 0;
        while (avn_waitrequest && n < 4) begin @(posedge clk); #1; n++; end
        chk({nm, "_wait0"}, 64'(avn_waitrequest), 64'd0);
        d = avn_readdata;
        chk({nm, "_data"}, 64'(d), 64'(e));
        @(posedge clk); #1;
        avn_read = 1'b0;
        step();
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] d, e1;
        int t5, tr, n;
        logic [4:0] a;
        logic [31:0] wd;

        tbl[0]  = '{5'h00, 4'b0001, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[1]  = '{5'h00, 4'b1110, 32'h0000_0000, 32'h0000_0001};
        tbl[2]  = '{5'h01, 4'b0001, 32'h0000_0000, 32'h0000_0000};
        tbl[3]  = '{5'h04, 4'b1111, 32'hFFFF_FFFE, 32'h0000_0000};
        tbl[4]  = '{5'h04, 4'b0001, 32'h0000_0001, 32'h0000_0001};
        tbl[5]  = '{5'h08, 4'b0101, 32'h1234_5678, 32'hFF34_FF78};
        tbl[6]  = '{5'h0C, 4'b1111, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        tbl[7]  = '{5'h18, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[8]  = '{5'h1F, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[9]  = '{5'h08, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[10] = '{5'h0E, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tb_shadow = 32'd0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_readdata", 64'(avn_readdata), 64'd0);
        chk("rst_waitrequest", 64'(avn_waitrequest), 64'd0);
        chk("rst_timer_irq", 64'(timer_interrupt), 64'd0);
        chk("rst_sw_irq", 64'(software_interrupt), 64'd0);
        rst_n = 1'b1;

        // 40 idle cycles at PRESCALE=4 give mtime = 10.
        repeat (40) step();
        rd("idle40_lo", 5'h10, d);
        chk("idle40_lo_const", 64'(d), 64'd10);
        chk("idle40_tirq", 64'(timer_interrupt), 64'd0);
        rd("idle40_hi", 5'h14, d);
        chk("idle40_hi_const", 64'(d), 64'd0);

        for (int i = 0; i < 11; i++) begin
            wr(tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b0);
            rd("tbl_rd", tbl[i].addr, d);
            chk("tbl_exp", 64'(d), 64'(tbl[i].exp));
        end

        // timer_interrupt rises one cycle after mtime reaches compare, falls one after raising it.
        wr(5'h10, 32'd0, 4'hF, 1'b0);
        wr(5'h14, 32'd0, 4'hF, 1'b0);
        wr(5'h0C, 32'd0, 4'hF, 1'b0);
        wr(5'h08, 32'd5, 4'hF, 1'b0);
        t5 = -1; tr = -1; n = 0;
        while (tr < 0 && n < 80) begin
            step();
            if (m_mtime == 64'd5 && t5 < 0) t5 = cyc;
            if (timer_interrupt && tr < 0) tr = cyc;
            n++;
        end
        chk("irq_rise_delay", 64'(tr - t5), 64'd1);
        wr(5'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
        chk("irq_hold", 64'(timer_interrupt), 64'd1);
        step();
        chk("irq_fall", 64'(timer_interrupt), 64'd0);

        // Coherent 64-bit read across the LO->HI carry.
        wr(5'h14, 32'd0, 4'hF, 1'b0);
        wr(5'h10, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rd("carry_lo", 5'h10, d);  chk("carry_lo_const", 64'(d), 64'hFFFF_FFFF);
        rd("carry_hi", 5'h14, d);  chk("carry_hi_const", 64'(d), 64'd0);
        rd("fresh_lo", 5'h10, d);  chk("fresh_lo_const", 64'(d), 64'd0);
        rd("fresh_hi", 5'h14, d);  chk("fresh_hi_const", 64'(d), 64'd1);

        // Disabled timer holds; an mtime write in a tick cycle wins over the increment.
        wr(5'h04, 32'd0, 4'hF, 1'b0);
        e1 = m_mtime[31:0];
        repeat (100) step();
        rd("frozen_lo", 5'h10, d);
        chk("frozen_hold", 64'(d), 64'(e1));
        wr(5'h04, 32'd1, 4'b0001, 1'b0);
        n = 0;
        while (!m_tick && n < 10) begin step(); n++; end
        chk("tick_align", 64'(m_tick), 64'd1);
        wr(5'h10, 32'h0000_0100, 4'hF, 1'b0);
        rd("tickwr_lo", 5'h10, d);
        chk("tickwr_const", 64'(d), 64'h100);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int op;
            op = int'($urandom_range(0, 11));
            a  = 5'($urandom_range(0, 31));
            if (a[4:2] == 3'd1)
                wd = {31'($urandom), 1'($urandom_range(0, 3) != 0)};
            else if ((a[4:2] == 3'd3 || a[4:2] == 3'd5) && $urandom_range(0, 3) != 0)
                wd = 32'($urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 1)
                wd = 32'($urandom_range(0, 40));
            else
                wd = $urandom;
            if (op < 4)       rd("rnd_rd", a, d);
            else if (op < 9)  wr(a, wd, 4'($urandom), 1'b0);
            else if (op < 10) wr(a, wd, 4'($urandom), 1'b1);
            else              step();
        end

        // Reset asserted during the read stall aborts the read.
        wr(5'h04, 32'd1, 4'hF, 1'b0);
        wr(5'h00, 32'd1, 4'hF, 1'b0);
        wr(5'h0C, 32'd0, 4'hF, 1'b0);
        wr(5'h08, 32'd0, 4'hF, 1'b0);
        rd("pre_rst_ctrl", 5'h04, d);
        chk("pre_rst_tirq", 64'(timer_interrupt), 64'd1);
        avn_read = 1'b1; avn_address = 5'h08;
        #1;
        chk("abort_wait1", 64'(avn_waitrequest), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_waitrequest", 64'(avn_waitrequest), 64'd0);
        chk("abort_readdata", 64'(avn_readdata), 64'd0);
        chk("abort_tirq", 64'(timer_interrupt), 64'd0);
        chk("abort_sirq", 64'(software_interrupt), 64'd0);
        @(negedge clk);
        avn_read = 1'b0;
        tb_shadow = 32'd0;
        step();
        rst_n = 1'b1;
        rd("post_rst_cmp_lo", 5'h08, d);  chk("post_rst_cmp_lo_const", 64'(d), 64'hFFFF_FFFF);
        rd("post_rst_cmp_hi", 5'h0C, d);  chk("post_rst_cmp_hi_const", 64'(d), 64'hFFFF_FFFF);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
